// File: rtl/req_dispatch.sv
// req_dispatch: pops requests from the input FIFO and issues them one at a
// time to the execution unit over valid/ready. A 4-entry tag scoreboard
// blocks re-use of outstanding req_id values and caps requests in flight.
//
// Packet layout (71 bits), used by fifo_req and exe_req:
//   [70]    req        (FIFO non-empty / packet valid)
//   [69:66] req_type
//   [65:64] req_id
//   [63:32] req_data1
//   [31:0]  req_data2
//
// Optional macro REQ_DISPATCH_SVA_EN compiles in inline assertions; the
// functional behaviour is identical with or without it.
module req_dispatch #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [70:0] fifo_req,
  output logic        fifo_read,
  output logic        exe_valid,
  input  logic        exe_ready,
  output logic [70:0] exe_req,
  input  logic        cmp_valid,
  input  logic [1:0]  cmp_id,
  output logic [2:0]  num_outstanding,
  output logic        err_cmp
);

  localparam int          REQ_BIT = 70;
  localparam int          ID_LSB  = 64;
  localparam logic [2:0]  MAX_CNT = 3'(MAX_OUTSTANDING);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  sb_q, sb_d;
  logic [3:0]  sb_set, sb_clr;
  logic [70:0] hold_q, hold_d;
  logic        err_q, err_d;
  logic        pop_ok;
  logic        head_vld;
  logic [1:0]  head_id;

  assign head_vld = fifo_req[REQ_BIT];
  assign head_id  = fifo_req[ID_LSB +: 2];

  // Scoreboard popcount; a held-but-unaccepted request already counts.
  always_comb begin
    num_outstanding = 3'd0;
    for (int i = 0; i < 4; i++) begin
      num_outstanding = num_outstanding + 3'(sb_q[i]);
    end
  end

  // Pop decision: head present, tag free, room in flight, and the hold
  // register is either empty or being handed off this cycle. Gated by
  // reset so nothing is popped while the block is held in reset.
  always_comb begin
    pop_ok = rst_b && head_vld && !sb_q[head_id] &&
             (num_outstanding < MAX_CNT) &&
             ((state_q == IDLE) || exe_ready);
  end

  assign fifo_read = pop_ok;

  // Per-tag set on pop and clear on completion; distinct tags may do both
  // in one cycle, and the same tag never can.
  for (genvar gi = 0; gi < 4; gi++) begin : g_sb
    assign sb_set[gi] = pop_ok && (head_id == 2'(gi));
    assign sb_clr[gi] = cmp_valid && (cmp_id == 2'(gi));
    assign sb_d[gi]   = (sb_q[gi] | sb_set[gi]) & ~sb_clr[gi];
  end

  // Hold register and sticky error next-state.
  always_comb begin
    hold_d = pop_ok ? fifo_req : hold_q;
    err_d  = err_q | (cmp_valid & ~sb_q[cmp_id]);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: stay in ISSUE while stalled or while back-to-back pops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop_ok) state_d = ISSUE;
      ISSUE:   if (exe_ready && !pop_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: present the held request only while issuing.
  always_comb begin
    exe_valid = (state_q == ISSUE);
    exe_req   = exe_valid ? hold_q : '0;
  end

  // Datapath registers: scoreboard, hold register, sticky error.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sb_q   <= '0;
      hold_q <= '0;
      err_q  <= 1'b0;
    end else begin
      sb_q   <= sb_d;
      hold_q <= hold_d;
      err_q  <= err_d;
    end
  end

  assign err_cmp = err_q;

`ifdef REQ_DISPATCH_SVA_EN
  // Held request must stay put until accepted.
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_b)
    exe_valid && !exe_ready |=> exe_valid && $stable(exe_req));

  // A pop only ever takes a present head whose tag is free.
  a_pop_legal: assert property (@(posedge clk) disable iff (!rst_b)
    fifo_read |-> fifo_req[REQ_BIT] && !sb_q[fifo_req[ID_LSB +: 2]]);

  // In-flight count never exceeds the configured cap.
  a_cap: assert property (@(posedge clk) disable iff (!rst_b)
    num_outstanding <= MAX_CNT);

  // A popped tag is marked outstanding on the following cycle.
  a_tag_set: assert property (@(posedge clk) disable iff (!rst_b)
    fifo_read |=> sb_q[$past(fifo_req[ID_LSB +: 2])]);
`else
  // Assertions not compiled in this build.
`endif

endmodule

// File: doc/req_dispatch.md
# req_dispatch

Pops requests from the input FIFO and issues them, one at a time, to the execution unit over a valid/ready handshake. A 4-entry scoreboard indexed by `req_id` blocks any request whose tag is still outstanding and caps the number of requests in flight. Completions from the execution unit retire tags. The block is the reader end of the input FIFO and sits between the FIFO and the execution unit.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 4: maximum tags in flight. Legal range 1..4.

Ports:
- `clk`  in  1  clock.
- `rst_b`  in  1  reset, asynchronous, active-low.
- `fifo_req`  in  req_pkt_type  FIFO head packet. It is all-zero when the FIFO is empty. Fields: `req` 1 bit, `req_type` 4 bits, `req_id` 2 bits, `req_data1` 32 bits, `req_data2` 32 bits.
- `fifo_read`  out  1  pop strobe, combinational, one cycle per pop.
- `exe_valid`  out  1  issue valid.
- `exe_ready`  in  1  execution unit accepts.
- `exe_req`  out  req_pkt_type  held request.
- `cmp_valid`  in  1  completion strobe.
- `cmp_id`  in  2  tag being retired.
- `num_outstanding`  out  3  popcount of the scoreboard.
- `err_cmp`  out  1  sticky: a completion arrived for a tag that was not outstanding.

## Operation
- FIFO non-empty is detected as `fifo_req.req == 1`.
- Scoreboard `sb[3:0]` is registered. `num_outstanding` = popcount(`sb`).
- Pop condition `pop_ok` requires all of:
  - `fifo_req.req`
  - `!sb[fifo_req.req_id]`
  - `num_outstanding < MAX_OUTSTANDING`
  - (state == IDLE) or (state == ISSUE and `exe_ready`)
- `fifo_read = pop_ok`. On the same edge the block:
  - captures `fifo_req` into the hold register;
  - sets `sb[fifo_req.req_id]`.
- FSM, two states:
  - IDLE: `exe_valid = 0`. If `pop_ok`, go to ISSUE.
  - ISSUE: `exe_valid = 1` and `exe_req` = hold register. If `exe_ready` and `pop_ok`, capture the new head and stay in ISSUE (back-to-back). If `exe_ready` and not `pop_ok`, go to IDLE. If not `exe_ready`, stay in ISSUE.
- While `exe_valid = 1` and `exe_ready = 0`, `exe_req` is stable.
- When `exe_valid = 0`, `exe_req` is driven to all-zero.
- Completion:
  - `cmp_valid` clears `sb[cmp_id]` on the next edge.
  - If `sb[cmp_id]` was already 0, `err_cmp` is set and held until reset.
- Hazard checks use the registered `sb` only. A tag retired in cycle N is poppable from cycle N+1.
- Same-tag set and clear in one cycle cannot occur: a pop requires the bit to be clear, and a clear requires it to be set.
- A set on one tag and a clear on a different tag in the same cycle both take effect.
- The tag is set at pop, not at handshake. A held-but-unaccepted request therefore counts as outstanding.

## Timing
- Reset values: state IDLE, `sb = 0`, `fifo_read = 0` (FIFO empty at reset), `exe_valid = 0`, `exe_req = 0`, `num_outstanding = 0`, `err_cmp = 0`.
- Latency: pop in cycle N gives `exe_valid` in cycle N+1. Minimum latency from FIFO head to issue is 1 cycle.
- Throughput: 1 request per cycle when `exe_ready` stays high and tags are free.
- Reset asserted mid-operation: state, scoreboard, hold register and `err_cmp` clear asynchronously. `exe_valid` drops immediately. The held request is discarded and no pop occurs.
- `cmp_valid` is sampled every cycle regardless of FSM state.

## Configuration
- `REQ_DISPATCH_SVA_EN` defined: inline assertions are compiled in. Each is disabled during reset.
  - `exe_valid && !exe_ready |=> exe_valid && $stable(exe_req)`
  - `fifo_read |-> fifo_req.req && !sb[fifo_req.req_id]`
  - `num_outstanding <= MAX_OUTSTANDING` always.
  - `fifo_read |=> sb[$past(fifo_req.req_id)]`
- Undefined: no assertions. Functional behaviour is identical with or without the macro.

## Test plan
- Single request (id 1, type 2, data1 `0x5`, data2 `0x3`) with FIFO head valid in cycle 0 and `exe_ready = 1`:
  - `fifo_read` high in cycle 0;
  - `exe_valid` and matching `exe_req` in cycle 1;
  - `num_outstanding = 1`;
  - `cmp_valid`/`cmp_id = 1` returns the count to 0.
- Back-to-back ids 0, 1, 2, 3 with `exe_ready = 1`: four consecutive `fifo_read` pulses, `exe_valid` high for 4 cycles, `num_outstanding = 4`. A fifth head with id 0 stalls until `cmp_id = 0`, then pops the following cycle.
- Backpressure: hold `exe_ready = 0` for 5 cycles in ISSUE. `exe_req` stays stable and `fifo_read` stays 0 even with a valid head. Release gives a one-cycle handshake.
- Tag hazard: id 2 outstanding and head id 2. No pop. `cmp_id = 2` in cycle N gives `fifo_read` in cycle N+1.
- Spurious completion with `cmp_id = 3` and `sb = 0`: `err_cmp` rises the next cycle and stays high until `rst_b` pulses. `sb` is unchanged.
- `MAX_OUTSTANDING = 2`: heads with ids 0, 1, 2 pop only 0 and 1. Id 2 pops one cycle after the first completion. Asserting `rst_b = 0` in ISSUE drops `exe_valid` immediately and clears `num_outstanding` to 0.
